// File: rtl/regbank_hs.sv
// regbank_hs -- CPU-visible register bank with valid/ready request and response
// channels, per-bit access types (RW / RO / W1C), byte write strobes,
// programmable wait states, out-of-range error response and an OR-reduced
// interrupt built from the W1C bits.
//
// Ports:
//   clk, rstn               clock (posedge) and asynchronous active-low reset
//   req_valid/req_ready     request handshake; req_write/req_addr/req_wdata/req_wstrb
//                           are captured on acceptance
//   rsp_valid/rsp_ready     response handshake; rsp_rdata/rsp_err held while valid
//   hw_in                   RO bits: live status value; W1C bits: set pulses
//   regs_out                current register contents, reg i at [i*DW +: DW]
//   irq                     registered OR of every W1C bit
module regbank_hs #(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 8,
  parameter int NUM_REGS    = 16,
  parameter int WAIT_CYCLES = 1,
  parameter logic [NUM_REGS*DATA_WIDTH-1:0] RESET_VAL = '0,
  parameter logic [NUM_REGS*DATA_WIDTH-1:0] RO_MASK   = '0,
  parameter logic [NUM_REGS*DATA_WIDTH-1:0] W1C_MASK  = '0
) (
  input  logic                           clk,
  input  logic                           rstn,
  input  logic                           req_valid,
  output logic                           req_ready,
  input  logic                           req_write,
  input  logic [ADDR_WIDTH-1:0]          req_addr,
  input  logic [DATA_WIDTH-1:0]          req_wdata,
  input  logic [DATA_WIDTH/8-1:0]        req_wstrb,
  output logic                           rsp_valid,
  input  logic                           rsp_ready,
  output logic [DATA_WIDTH-1:0]          rsp_rdata,
  output logic                           rsp_err,
  input  logic [NUM_REGS*DATA_WIDTH-1:0] hw_in,
  output logic [NUM_REGS*DATA_WIDTH-1:0] regs_out,
  output logic                           irq
);

  localparam int DW = DATA_WIDTH;
  localparam int NB = DATA_WIDTH / 8;
  localparam logic [3:0] LAST_WAIT = 4'(WAIT_CYCLES - 1);
  localparam logic [ADDR_WIDTH:0] NUM_REGS_W = (ADDR_WIDTH + 1)'(NUM_REGS);
  localparam logic IRQ_RST = |(RESET_VAL & W1C_MASK & ~RO_MASK);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_e;

  state_e                     state_q, state_d;
  logic [3:0]                 cnt_q, cnt_d;
  logic                       wr_q, wr_d;
  logic [ADDR_WIDTH-1:0]      addr_q, addr_d;
  logic [DW-1:0]              wdata_q, wdata_d;
  logic [NB-1:0]              wstrb_q, wstrb_d;
  logic [NUM_REGS*DW-1:0]     regs_q, regs_d;
  logic [DW-1:0]              rdata_q, rdata_d;
  logic                       err_q, err_d;
  logic                       irq_q, irq_d;

  logic                       accept, commit, in_range;
  logic                       txn_write;
  logic [ADDR_WIDTH-1:0]      txn_addr;
  logic [DW-1:0]              txn_wdata, strb_bits, rd_word;
  logic [NB-1:0]              txn_wstrb;

  // RO beats W1C on overlapping bits; anything neither RO nor W1C is RW.
  function automatic logic [DW-1:0] next_bits(
    input logic [DW-1:0] cur, input logic [DW-1:0] hw, input logic [DW-1:0] ro,
    input logic [DW-1:0] w1c_raw, input logic [DW-1:0] wbits, input logic [DW-1:0] wdata);
    logic [DW-1:0] w1c, rw;
    w1c = w1c_raw & ~ro;
    rw  = ~(ro | w1c_raw);
    return (ro & hw)
         | (w1c & (hw | (cur & ~(wbits & wdata))))
         | (rw & ((wbits & wdata) | (cur & ~wbits)));
  endfunction

  assign req_ready = (state_q == S_IDLE);
  assign rsp_valid = (state_q == S_RESP);
  assign accept    = req_valid && req_ready;

  // With zero wait states the commit happens on the accept edge itself, so the
  // live request fields are used instead of the (not yet loaded) latches.
  assign txn_write = (state_q == S_IDLE) ? req_write : wr_q;
  assign txn_addr  = (state_q == S_IDLE) ? req_addr  : addr_q;
  assign txn_wdata = (state_q == S_IDLE) ? req_wdata : wdata_q;
  assign txn_wstrb = (state_q == S_IDLE) ? req_wstrb : wstrb_q;
  assign in_range  = ({1'b0, txn_addr} < NUM_REGS_W);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    commit  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (WAIT_CYCLES > 0) begin
            state_d = S_WAIT;
            cnt_d   = 4'd0;
          end else begin
            state_d = S_RESP;
            commit  = 1'b1;
          end
        end
      end
      S_WAIT: begin
        if (cnt_q == LAST_WAIT) begin
          state_d = S_RESP;
          commit  = 1'b1;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      S_RESP: begin
        if (rsp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    wr_d    = wr_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    wstrb_d = wstrb_q;
    if (accept) begin
      wr_d    = req_write;
      addr_d  = req_addr;
      wdata_d = req_wdata;
      wstrb_d = req_wstrb;
    end
  end

  always_comb begin
    strb_bits = '0;
    for (int b = 0; b < NB; b++) strb_bits[b*8 +: 8] = {8{txn_wstrb[b]}};
  end

  // Register update and read mux; read data is the pre-commit value.
  always_comb begin
    regs_d  = regs_q;
    rd_word = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      regs_d[i*DW +: DW] = next_bits(regs_q[i*DW +: DW], hw_in[i*DW +: DW],
                                     RO_MASK[i*DW +: DW], W1C_MASK[i*DW +: DW],
                                     (commit && txn_write && in_range &&
                                      (txn_addr == ADDR_WIDTH'(i))) ? strb_bits : '0,
                                     txn_wdata);
      if (txn_addr == ADDR_WIDTH'(i)) rd_word = regs_q[i*DW +: DW];
    end
    irq_d = |(regs_d & W1C_MASK & ~RO_MASK);
  end

  always_comb begin
    rdata_d = rdata_q;
    err_d   = err_q;
    if (commit) begin
      err_d   = !in_range;
      rdata_d = (!txn_write && in_range) ? rd_word : '0;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      regs_q  <= RESET_VAL;
      rdata_q <= '0;
      err_q   <= 1'b0;
      irq_q   <= IRQ_RST;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      regs_q  <= regs_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      irq_q   <= irq_d;
    end
  end

  // Transaction latches carry data only; they are always reloaded before use.
  always_ff @(posedge clk) begin
    wr_q    <= wr_d;
    addr_q  <= addr_d;
    wdata_q <= wdata_d;
    wstrb_q <= wstrb_d;
  end

  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;
  assign regs_out  = regs_q;
  assign irq       = irq_q;

endmodule
